// File: rtl/branch_pred_unit_if.sv
// Fetch lookup, execute resolve, redirect and statistics signals of the branch predictor.
// The pipeline side uses the master modport; the predictor uses the slave modport.
interface branch_pred_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic [XLEN-1:0]  if_pc;
  logic             if_pred_taken;
  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc;
  logic [2:0]       ex_branch;
  logic             ex_less;
  logic             ex_zero;
  logic [XLEN-1:0]  ex_imm;
  logic [XLEN-1:0]  ex_rs1;
  logic             ex_pred_taken;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] stat_branches;
  logic [CNT_W-1:0] stat_misses;

  modport master (
    output if_pc, ex_valid, ex_pc, ex_branch, ex_less, ex_zero, ex_imm, ex_rs1, ex_pred_taken,
    input  if_pred_taken, redirect_valid, redirect_pc, stat_branches, stat_misses
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_branch, ex_less, ex_zero, ex_imm, ex_rs1, ex_pred_taken,
    output if_pred_taken, redirect_valid, redirect_pc, stat_branches, stat_misses
  );
endinterface

// File: rtl/branch_pred_unit.sv
// Branch direction predictor (2-bit saturating counter table) and resolver
// producing a registered redirect on mispredicts and jumps, plus branch/miss statistics.
module branch_pred_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int IDX_LSB     = 2,
  parameter int CNT_W       = 32
) (
  input logic          clk,
  input logic          rst_n,
  branch_pred_unit_if.slave bp
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d [BHT_ENTRIES];
  logic             redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] stat_branches_q, stat_branches_d;
  logic [CNT_W-1:0] stat_misses_q, stat_misses_d;

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             is_cond;
  logic             is_jal;
  logic             is_jalr;
  logic             taken;
  logic             mispredict;
  logic [XLEN-1:0]  target;
  logic [1:0]       cnt;

  assign if_idx = bp.if_pc[IDX_LSB +: IDX_W];
  assign ex_idx = bp.ex_pc[IDX_LSB +: IDX_W];

  // Lookup reads the registered table, so a same-cycle update is not bypassed.
  assign bp.if_pred_taken = bht_q[if_idx][1];

  always_comb begin
    is_cond    = bp.ex_valid && bp.ex_branch[2];
    is_jal     = bp.ex_valid && (bp.ex_branch == 3'b001);
    is_jalr    = bp.ex_valid && (bp.ex_branch == 3'b010);
    taken      = bp.ex_branch[1] ? (bp.ex_less ^ bp.ex_branch[0])
                                 : (bp.ex_zero ^ bp.ex_branch[0]);
    mispredict = is_cond && (taken != bp.ex_pred_taken);

    if (is_jalr) begin
      target = (bp.ex_rs1 + bp.ex_imm) & ~XLEN'(1);
    end else if (is_jal || taken) begin
      target = bp.ex_pc + bp.ex_imm;
    end else begin
      target = bp.ex_pc + XLEN'(4);
    end
  end

  always_comb begin
    bht_d = bht_q;
    cnt   = bht_q[ex_idx];
    if (is_cond) begin
      if (taken && (cnt != 2'b11)) begin
        bht_d[ex_idx] = cnt + 2'b01;
      end else if (!taken && (cnt != 2'b00)) begin
        bht_d[ex_idx] = cnt - 2'b01;
      end
    end
  end

  always_comb begin
    redirect_valid_d = mispredict || is_jal || is_jalr;
    redirect_pc_d    = redirect_valid_d ? target : redirect_pc_q;
    stat_branches_d  = stat_branches_q;
    stat_misses_d    = stat_misses_q;
    if (is_cond && (stat_branches_q != '1)) begin
      stat_branches_d = stat_branches_q + CNT_W'(1);
    end
    if (mispredict && (stat_misses_q != '1)) begin
      stat_misses_d = stat_misses_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      stat_branches_q  <= '0;
      stat_misses_q    <= '0;
    end else begin
      bht_q            <= bht_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      stat_branches_q  <= stat_branches_d;
      stat_misses_q    <= stat_misses_d;
    end
  end

  assign bp.redirect_valid = redirect_valid_q;
  assign bp.redirect_pc    = redirect_pc_q;
  assign bp.stat_branches  = stat_branches_q;
  assign bp.stat_misses    = stat_misses_q;
endmodule

// File: doc/branch_pred_unit.md
# branch_pred_unit

Parametrised branch direction predictor and resolver for the pipelined NPC core. A fetch-side lookup port gives a taken/not-taken guess from a table of 2-bit saturating counters indexed by PC. An execute-side resolve port evaluates the branch condition with the same `Branch`/`Less`/`Zero` encoding the single-cycle core uses, and computes the real next PC. It trains the table, flags a mispredict one cycle later with the redirect PC, and keeps saturating branch/miss statistics.

## Interface
- `XLEN`, 32: address/data width.
- `BHT_ENTRIES`, 16: counter-table depth; power of two, at least 2.
- `IDX_LSB`, 2: lowest PC bit used for the table index; index = `pc[IDX_LSB +: log2(BHT_ENTRIES)]`.
- `CNT_W`, 32: width of the statistics counters.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `if_pc` in XLEN: fetch PC to look up.
- `if_pred_taken` out 1: combinational prediction, equal to bit 1 of the counter addressed by `if_pc`.
- `ex_valid` in 1: a resolve request is present this cycle.
- `ex_pc` in XLEN: PC of the resolving instruction.
- `ex_branch` in 3: branch type. 000 none; 001 jal; 010 jalr; 100 beq (taken if Zero); 101 bne (taken if !Zero); 110 blt/bltu (taken if Less); 111 bge/bgeu (taken if !Less); 011 is illegal and treated as none.
- `ex_less` in 1: ALU less-than result.
- `ex_zero` in 1: ALU zero result.
- `ex_imm` in XLEN: sign-extended immediate.
- `ex_rs1` in XLEN: rs1 value, used by jalr.
- `ex_pred_taken` in 1: the prediction that was made at fetch, carried down the pipeline.
- `redirect_valid` out 1: registered one-cycle mispredict/redirect pulse.
- `redirect_pc` out XLEN: registered correct next PC.
- `stat_branches` out CNT_W: number of conditional branches resolved.
- `stat_misses` out CNT_W: number of conditional mispredicts.

## Operation
- **Table.**
  - `BHT_ENTRIES` 2-bit counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - All entries reset to 01.
- **Conditional resolve.** Applies when `ex_valid` is high and `ex_branch[2]` is 1.
  - `taken` is `ex_zero ^ ex_branch[0]` for 10x, and `ex_less ^ ex_branch[0]` for 11x.
  - The counter at the `ex_pc` index increments if taken (saturating at 11) and decrements otherwise (saturating at 00).
  - Mispredict = `taken != ex_pred_taken`.
  - `stat_branches` increments; `stat_misses` increments on a mispredict. Both saturate at all-ones.
- **Target arithmetic.** All modulo 2^XLEN.
  - taken: `ex_pc + ex_imm`.
  - not taken: `ex_pc + 4`.
  - jal: `ex_pc + ex_imm`.
  - jalr: `(ex_rs1 + ex_imm) & ~1`.
- **Unconditional (jal/jalr).**
  - Always redirect; prediction is ignored.
  - No table update and no statistics update.
- **None/illegal, or `ex_valid` low.** No state change and no redirect.
- **Read/write collision.** A lookup and an update to the same index in the same cycle: the lookup returns the pre-update value. There is no bypass.

## Timing
- Reset values: every counter 01; `redirect_valid` 0; `redirect_pc` 0; both statistics counters 0. Assertion of `rst_n` takes effect immediately, without waiting for a clock.
- Reset mid-operation discards any pending redirect. Release of `rst_n` is synchronised externally.
- Lookup latency is 0 cycles (combinational from `if_pc`).
- Resolve latency:
  - A resolve in cycle N drives `redirect_valid`/`redirect_pc` in cycle N+1.
  - The pulse lasts exactly one cycle unless cycle N+1 also carries a redirecting resolve.
  - Back-to-back redirecting resolves give consecutive pulses, each with its own PC.
- `redirect_pc` holds its last value when `redirect_valid` is 0.
- Table and statistics writes are visible from cycle N+1.
- No handshake: the block accepts one resolve every cycle, and the pipeline guarantees `ex_*` is stable while `ex_valid` is high.

## Test plan
- **Reset:** drive `rst_n`=0 mid-cycle -> outputs clear asynchronously; `if_pred_taken`=0 for every `if_pc`; stats 0.
- **Training:** beq with `ex_zero`=1 at `ex_pc`=0x80000010, three times, with `ex_pred_taken` following `if_pred_taken`.
  - First resolve mispredicts: redirect 0x80000010+imm, `stat_misses`=1.
  - Counter walks 01->10->11; `if_pred_taken`=1 at index 4 from the cycle after the first resolve.
- **Saturation:** five not-taken bne at the same PC (`ex_zero`=1) -> counter sticks at 00 with no wrap; fall-through redirect is `ex_pc`+4 only when the prediction was taken.
- **Jumps:** jalr with `ex_rs1`=0x80001003 and `ex_imm`=4 -> `redirect_pc`=0x80001006 next cycle; table and stats unchanged. jal with `ex_pc`=0xFFFFFFFC and `ex_imm`=8 -> `redirect_pc`=0x00000004 (wrap-around).
- **Collision:** `if_pc` and `ex_pc` share an index while the counter is 01 and a taken update occurs -> `if_pred_taken`=0 that cycle, 1 the next.
- **Statistics:** with `CNT_W`=4, issue 20 conditional mispredicts -> both counters stop at 15.
